// File: rtl/pattern_scanner_if.sv
// Signal bundle for pattern_scanner: control/data inputs from the host and the
// scanner's status outputs, plus a state debug view for checkers.
interface pattern_scanner_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    // No valid/ready handshake here: sample_en alone qualifies serial_in on each
    // rising edge and the scanner never applies backpressure.
    logic             load;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] mask;
    logic             sample_en;
    logic             serial_in;
    logic             overlap_en;
    logic             clear;
    logic             armed;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic [1:0]       state_dbg;

    modport master (
        output load, pattern, mask, sample_en, serial_in, overlap_en, clear,
        input  armed, match, match_count, state_dbg
    );

    modport slave (
        input  load, pattern, mask, sample_en, serial_in, overlap_en, clear,
        output armed, match, match_count, state_dbg
    );
endinterface

// File: rtl/pattern_scanner.sv
// Serial pattern scanner with per-bit mask and optional overlap; the match
// counter is built only when PATTERN_SCANNER_COUNT_EN is defined.
module pattern_scanner #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               reset_n,
    pattern_scanner_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    localparam int FC_W = $clog2(WIDTH + 1);
    localparam logic [FC_W-1:0] FULL = FC_W'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] win_q, win_d;
    logic [FC_W-1:0]  fill_q, fill_d;
    logic             match_q, match_d;
`ifdef PATTERN_SCANNER_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;
`endif

    logic [WIDTH-1:0] win_sh;
    logic [FC_W-1:0]  fill_sh;
    logic             shift;
    logic             hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            mask_q    <= '0;
            win_q     <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
`ifdef PATTERN_SCANNER_COUNT_EN
            count_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            mask_q    <= mask_d;
            win_q     <= win_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
`ifdef PATTERN_SCANNER_COUNT_EN
            count_q   <= count_d;
`endif
        end
    end

    // Load and clear both suppress a same-cycle sample.
    always_comb begin
        win_sh  = {win_q[WIDTH-2:0], bus.serial_in};
        fill_sh = (fill_q == FULL) ? FULL : fill_q + FC_W'(1);
        shift   = bus.sample_en && (state_q != S_IDLE) && !bus.load && !bus.clear;
        hit     = shift && (fill_sh == FULL) && (((win_sh ^ pattern_q) & mask_q) == '0);
    end

    always_comb begin
        pattern_d = pattern_q;
        mask_d    = mask_q;
        win_d     = win_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
`ifdef PATTERN_SCANNER_COUNT_EN
        count_d   = count_q;
`endif
        if (bus.load) begin
            pattern_d = bus.pattern;
            mask_d    = bus.mask;
            win_d     = '0;
            fill_d    = '0;
`ifdef PATTERN_SCANNER_COUNT_EN
            count_d   = '0;
`endif
        end else if (bus.clear) begin
            win_d     = '0;
            fill_d    = '0;
`ifdef PATTERN_SCANNER_COUNT_EN
            count_d   = '0;
`endif
        end else if (shift) begin
            win_d  = win_sh;
            fill_d = fill_sh;
            if (hit) begin
                match_d = 1'b1;
                // Non-overlapping mode demands a completely fresh window.
                fill_d  = bus.overlap_en ? FULL : '0;
`ifdef PATTERN_SCANNER_COUNT_EN
                count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
`endif
            end
        end
    end

    always_comb begin
        state_d = S_IDLE;
        if (bus.load || (state_q != S_IDLE)) begin
            state_d = (fill_d == FULL) ? S_RUN : S_FILL;
        end
    end

    always_comb begin
        bus.armed     = (state_q != S_IDLE);
        bus.match     = match_q;
        bus.state_dbg = state_q;
`ifdef PATTERN_SCANNER_COUNT_EN
        bus.match_count = count_q;
`else
        bus.match_count = '0;
`endif
    end
endmodule

// File: tb/tb_pattern_scanner.sv
// Directed bench for pattern_scanner (WIDTH=5, CNT_W=2) with a queue-based
// reference model compared every cycle plus literal spot checks.
module tb_pattern_scanner;
    localparam int WIDTH = 5;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PATTERN_SCANNER_COUNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    pattern_scanner_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) sif ();

    pattern_scanner #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sif.slave)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Reference model: keeps the samples seen since the last restart.
    bit               m_q[$];
    logic             m_armed = 1'b0;
    logic [WIDTH-1:0] m_pat = '0;
    logic [WIDTH-1:0] m_mask = '0;
    logic             m_match = 1'b0;
    int               m_count = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_armed = 1'b0;
            m_pat   = '0;
            m_mask  = '0;
            m_match = 1'b0;
            m_count = 0;
        end else begin
            m_match = 1'b0;
            if (sif.load) begin
                m_pat   = sif.pattern;
                m_mask  = sif.mask;
                m_armed = 1'b1;
                m_count = 0;
                m_q.delete();
            end else if (sif.clear) begin
                m_q.delete();
                m_count = 0;
            end else if (sif.sample_en && m_armed) begin
                logic [WIDTH-1:0] w;
                m_q.push_back(sif.serial_in);
                if (m_q.size() > WIDTH) void'(m_q.pop_front());
                if (m_q.size() == WIDTH) begin
                    for (int i = 0; i < WIDTH; i++) w[WIDTH-1-i] = m_q[i];
                    if (((w ^ m_pat) & m_mask) == '0) begin
                        m_match = 1'b1;
                        if (m_count < CNT_MAX) m_count = m_count + 1;
                        if (!sif.overlap_en) m_q.delete();
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard compare, every cycle just after the active edge
    always @(posedge clk) begin
        #1;
        check("match", int'(sif.match), int'(m_match));
        check("armed", int'(sif.armed), int'(m_armed));
        check("match_count", int'(sif.match_count), CNT_ON ? m_count : 0);
    end

    // Driver tasks: inputs change on the falling edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_load(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] m, input logic ov);
        sif.load = 1'b1; sif.pattern = p; sif.mask = m; sif.overlap_en = ov;
        @(negedge clk);
        sif.load = 1'b0;
    endtask

    task automatic do_clear();
        sif.clear = 1'b1;
        @(negedge clk);
        sif.clear = 1'b0;
    endtask

    task automatic send(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sif.sample_en = 1'b1;
            sif.serial_in = bits[i];
            @(negedge clk);
        end
        sif.sample_en = 1'b0;
        sif.serial_in = 1'b0;
    endtask

    task automatic lit(input string name, input int dut_v, input int mdl_v, input int exp);
        check({name, "_dut"}, dut_v, exp);
        check({name, "_model"}, mdl_v, exp);
    endtask

    initial begin
        sif.load = 1'b0; sif.pattern = '0; sif.mask = '0; sif.sample_en = 1'b0;
        sif.serial_in = 1'b0; sif.overlap_en = 1'b1; sif.clear = 1'b0;
        #1 reset_n = 1'b0;
        step(3);
        lit("reset_armed", int'(sif.armed), int'(m_armed), 0);
        lit("reset_count", int'(sif.match_count), m_count, 0);
        reset_n = 1'b1;
        step(1);

        // Idle: samples ignored
        send(32'b10110, 5);
        lit("idle_match", int'(sif.match), int'(m_match), 0);

        // Basic full-mask match
        do_load(5'b10110, 5'b11111, 1'b1);
        send(32'b10110, 5);
        lit("basic_match", int'(sif.match), int'(m_match), 1);
        check("basic_count", int'(sif.match_count), CNT_ON);
        step(1);
        lit("basic_pulse_end", int'(sif.match), int'(m_match), 0);

        // Overlapping vs non-overlapping on 1010101
        do_load(5'b10101, 5'b11111, 1'b1);
        send(32'b10101, 5);
        lit("ov1_first", int'(sif.match), int'(m_match), 1);
        send(32'b01, 2);
        lit("ov1_second", int'(sif.match), int'(m_match), 1);
        check("ov1_count", int'(sif.match_count), CNT_ON * 2);
        do_load(5'b10101, 5'b11111, 1'b0);
        send(32'b10101, 5);
        lit("ov0_first", int'(sif.match), int'(m_match), 1);
        send(32'b01, 2);
        lit("ov0_second", int'(sif.match), int'(m_match), 0);
        check("ov0_count", int'(sif.match_count), CNT_ON);

        // Don't-care bits
        do_load(5'b10001, 5'b10011, 1'b1);
        send(32'b11101, 5);
        lit("mask_hit", int'(sif.match), int'(m_match), 1);
        do_load(5'b10001, 5'b10011, 1'b1);
        send(32'b01101, 5);
        lit("mask_miss", int'(sif.match), int'(m_match), 0);

        // All don't-care: saturation, then clear
        do_load(5'b00000, 5'b00000, 1'b1);
        send(32'b110100101, 9);
        lit("zero_mask_match", int'(sif.match), int'(m_match), 1);
        check("sat_count", int'(sif.match_count), CNT_ON * 3);
        do_clear();
        check("clear_count", int'(sif.match_count), 0);
        send(32'b1010, 4);
        lit("clear_refill", int'(sif.match), int'(m_match), 0);
        send(32'b1, 1);
        lit("clear_refull", int'(sif.match), int'(m_match), 1);

        // load or clear together with sample_en: sample dropped; load beats clear
        sif.sample_en = 1'b1; sif.serial_in = 1'b1; sif.clear = 1'b1;
        do_load(5'b11111, 5'b11111, 1'b1);
        sif.clear = 1'b0;
        send(32'b1111, 4);
        lit("load_drops_sample", int'(sif.match), int'(m_match), 0);
        sif.clear = 1'b1; sif.sample_en = 1'b1; sif.serial_in = 1'b1;
        step(1);
        sif.clear = 1'b0;
        send(32'b11111, 5);
        lit("clear_drops_sample", int'(sif.match), int'(m_match), 1);

        // Mixed stream with gaps and overlap toggling
        do_load(5'b11011, 5'b11011, 1'b1);
        for (int i = 0; i < 200; i++) begin
            sif.sample_en  = ($urandom_range(0, 3) != 0);
            sif.serial_in  = ($urandom_range(0, 2) != 0);
            sif.overlap_en = $urandom_range(0, 1);
            sif.clear      = ($urandom_range(0, 60) == 0);
            @(negedge clk);
        end
        sif.sample_en = 1'b0; sif.clear = 1'b0; sif.overlap_en = 1'b1;

        // Reset mid-scan discards the pattern
        do_load(5'b10110, 5'b11111, 1'b1);
        send(32'b101, 3);
        #2 reset_n = 1'b0;
        #1;
        lit("async_armed", int'(sif.armed), int'(m_armed), 0);
        @(negedge clk);
        reset_n = 1'b1;
        send(32'b10110, 5);
        lit("post_reset_armed", int'(sif.armed), int'(m_armed), 0);
        lit("post_reset_match", int'(sif.match), int'(m_match), 0);
        do_load(5'b10110, 5'b11111, 1'b1);
        send(32'b10110, 5);
        lit("reload_match", int'(sif.match), int'(m_match), 1);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
